rs_aged: RTL and testbench

RS_AGED -- requirements
Module: rs_aged

---
 rtl/rs_aged_pkg.sv | 24 ++
 rtl/rs_aged_if.sv | 53 +++++
 rtl/rs_aged_age_pick.sv | 26 ++
 rtl/rs_aged.sv | 189 ++++++++++++++++++
 tb/tb_rs_aged.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_aged_pkg.sv
// Shared constants for the aged reservation station: default widths,
// the "no dependency" ROB tag and the ALU opcode encodings.
package rs_aged_pkg;

  localparam int RS_DEPTH_DEF  = 16;
  localparam int ROB_TAG_W_DEF = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int OP_W_DEF      = 6;

  // A producer tag of zero means the operand value is already present.
  localparam int ZERO_TAG_ROB  = 0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD = 6'h00,
    OP_SUB = 6'h01,
    OP_AND = 6'h02,
    OP_OR  = 6'h03,
    OP_XOR = 6'h04,
    OP_SLL = 6'h05,
    OP_SRL = 6'h06,
    OP_SLT = 6'h07
  } alu_op_e;

endpackage

// File: rtl/rs_aged_if.sv
// Dispatch / CDB / issue bundle between the decoder side and the station.
//
// Handshakes: dispatch transfers on a rising edge where in_dispatch_valid=1
// and out_full=0 (out_full acts as the inverted ready), with rdy=1 and
// in_flush=0. The CDB is a broadcast with no ready. The issue bundle
// (out_alu_*) has no backpressure: out_alu_valid=1 for one cycle per issue.
interface rs_aged_if
  import rs_aged_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF
) ();

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  logic                 in_flush;
  logic                 in_dispatch_valid;
  logic [OP_W-1:0]      in_dispatch_op;
  logic [ROB_TAG_W-1:0] in_dispatch_rob_tag;
  logic [DATA_W-1:0]    in_dispatch_value1;
  logic [DATA_W-1:0]    in_dispatch_value2;
  logic [ROB_TAG_W-1:0] in_dispatch_tag1;
  logic [ROB_TAG_W-1:0] in_dispatch_tag2;
  logic                 in_cdb_valid;
  logic [ROB_TAG_W-1:0] in_cdb_tag;
  logic [DATA_W-1:0]    in_cdb_value;
  logic                 out_full;
  logic [CNT_W-1:0]     out_count;
  logic                 out_alu_valid;
  logic [OP_W-1:0]      out_alu_op;
  logic [DATA_W-1:0]    out_alu_value1;
  logic [DATA_W-1:0]    out_alu_value2;
  logic [ROB_TAG_W-1:0] out_alu_rob_tag;

  modport master (
    output in_flush, in_dispatch_valid, in_dispatch_op, in_dispatch_rob_tag,
           in_dispatch_value1, in_dispatch_value2, in_dispatch_tag1,
           in_dispatch_tag2, in_cdb_valid, in_cdb_tag, in_cdb_value,
    input  out_full, out_count, out_alu_valid, out_alu_op, out_alu_value1,
           out_alu_value2, out_alu_rob_tag
  );

  modport slave (
    input  in_flush, in_dispatch_valid, in_dispatch_op, in_dispatch_rob_tag,
           in_dispatch_value1, in_dispatch_value2, in_dispatch_tag1,
           in_dispatch_tag2, in_cdb_valid, in_cdb_tag, in_cdb_value,
    output out_full, out_count, out_alu_valid, out_alu_op, out_alu_value1,
           out_alu_value2, out_alu_rob_tag
  );

endinterface

// File: rtl/rs_aged_age_pick.sv
// Oldest-ready picker: older[k][i]=1 means entry k was dispatched before
// entry i. An entry is granted when it is ready and no ready entry is older.
module rs_age_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant,
  output logic                valid
);

  logic [N-1:0] blocked;

  // Block every ready entry that has an older ready entry.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        blocked[i] = blocked[i] | (ready[k] & older[k][i]);
      end
    end
    grant = ready & ~blocked;
    valid = |ready;
  end

endmodule

// File: rtl/rs_aged.sv
// Reservation station with age-ordered issue. Entries wait for their
// producer tags on the CDB; the oldest ready entry issues every edge.
module rs_aged
  import rs_aged_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  rs_aged_if.slave   bus
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ROB_TAG_W-1:0] ZERO_TAG = ROB_TAG_W'(ZERO_TAG_ROB);

  logic [RS_DEPTH-1:0]                busy_q, busy_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older_q, older_d;
  logic [OP_W-1:0]      op_q  [RS_DEPTH], op_d  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] rob_q [RS_DEPTH], rob_d [RS_DEPTH];
  logic [ROB_TAG_W-1:0] t1_q  [RS_DEPTH], t1_d  [RS_DEPTH];
  logic [ROB_TAG_W-1:0] t2_q  [RS_DEPTH], t2_d  [RS_DEPTH];
  logic [DATA_W-1:0]    v1_q  [RS_DEPTH], v1_d  [RS_DEPTH];
  logic [DATA_W-1:0]    v2_q  [RS_DEPTH], v2_d  [RS_DEPTH];

  logic                 alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    alu_v1_q, alu_v1_d;
  logic [DATA_W-1:0]    alu_v2_q, alu_v2_d;
  logic [ROB_TAG_W-1:0] alu_rob_q, alu_rob_d;

  logic [RS_DEPTH-1:0]  ready;
  logic [RS_DEPTH-1:0]  grant;
  logic                 pick_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     free_idx;
  logic [CNT_W-1:0]     count;
  logic                 full;

  // Readiness, occupancy and the lowest free slot, all from registered state.
  always_comb begin
    full     = &busy_q;
    count    = '0;
    free_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = busy_q[i] && (t1_q[i] == ZERO_TAG) && (t2_q[i] == ZERO_TAG);
      count    = count + {{(CNT_W-1){1'b0}}, busy_q[i]};
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  rs_age_pick #(.N(RS_DEPTH)) u_pick (
    .ready (ready),
    .older (older_q),
    .grant (grant),
    .valid (pick_valid)
  );

  // Encode the one-hot grant into an entry index.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  // Next state: flush, CDB wake-up, issue and dispatch.
  always_comb begin
    busy_d      = busy_q;
    older_d     = older_q;
    op_d        = op_q;
    rob_d       = rob_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_rob_d   = alu_rob_q;
    if (rdy) begin
      if (bus.in_flush) begin
        busy_d      = '0;
        alu_valid_d = 1'b0;
      end else begin
        if (bus.in_cdb_valid) begin
          for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy_q[i] && t1_q[i] != ZERO_TAG && t1_q[i] == bus.in_cdb_tag) begin
              v1_d[i] = bus.in_cdb_value;
              t1_d[i] = ZERO_TAG;
            end
            if (busy_q[i] && t2_q[i] != ZERO_TAG && t2_q[i] == bus.in_cdb_tag) begin
              v2_d[i] = bus.in_cdb_value;
              t2_d[i] = ZERO_TAG;
            end
          end
        end
        // The issued entry is ready (tags zero), so wake-up never touches it.
        alu_valid_d = pick_valid;
        if (pick_valid) begin
          alu_op_d        = op_q[sel_idx];
          alu_v1_d        = v1_q[sel_idx];
          alu_v2_d        = v2_q[sel_idx];
          alu_rob_d       = rob_q[sel_idx];
          busy_d[sel_idx] = 1'b0;
        end
        // free_idx comes from busy_q, so a slot freed this edge is not reused.
        if (bus.in_dispatch_valid && !full) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = bus.in_dispatch_op;
          rob_d[free_idx]  = bus.in_dispatch_rob_tag;
          if (bus.in_cdb_valid && bus.in_dispatch_tag1 != ZERO_TAG &&
              bus.in_dispatch_tag1 == bus.in_cdb_tag) begin
            v1_d[free_idx] = bus.in_cdb_value;
            t1_d[free_idx] = ZERO_TAG;
          end else begin
            v1_d[free_idx] = bus.in_dispatch_value1;
            t1_d[free_idx] = bus.in_dispatch_tag1;
          end
          if (bus.in_cdb_valid && bus.in_dispatch_tag2 != ZERO_TAG &&
              bus.in_dispatch_tag2 == bus.in_cdb_tag) begin
            v2_d[free_idx] = bus.in_cdb_value;
            t2_d[free_idx] = ZERO_TAG;
          end else begin
            v2_d[free_idx] = bus.in_dispatch_value2;
            t2_d[free_idx] = bus.in_dispatch_tag2;
          end
          // New entry is younger than every entry currently busy. Stale bits
          // against free slots are rewritten when those slots are reused.
          for (int j = 0; j < RS_DEPTH; j++) begin
            older_d[free_idx][j] = 1'b0;
            older_d[j][free_idx] = busy_q[j];
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      older_q     <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
      alu_rob_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      older_q     <= older_d;
      op_q        <= op_d;
      rob_q       <= rob_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  assign bus.out_full        = full;
  assign bus.out_count       = count;
  assign bus.out_alu_valid   = alu_valid_q;
  assign bus.out_alu_op      = alu_op_q;
  assign bus.out_alu_value1  = alu_v1_q;
  assign bus.out_alu_value2  = alu_v2_q;
  assign bus.out_alu_rob_tag = alu_rob_q;

endmodule

// File: tb/tb_rs_aged.sv
// Directed bench for rs_aged: hand-computed expectations for reset, issue
// latency, age ordering with slot reuse, CDB bypass, full, flush, rdy hold
// and mid-operation reset.
module tb_rs_aged;
  import rs_aged_pkg::*;

  localparam int D  = 16;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TW-1:0] exp_q[$];

  rs_aged_if #(.RS_DEPTH(D), .ROB_TAG_W(TW), .DATA_W(DW), .OP_W(OW)) bus ();

  rs_aged #(.RS_DEPTH(D), .ROB_TAG_W(TW), .DATA_W(DW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_flush            = 1'b0;
    bus.in_dispatch_valid   = 1'b0;
    bus.in_dispatch_op      = '0;
    bus.in_dispatch_rob_tag = '0;
    bus.in_dispatch_value1  = '0;
    bus.in_dispatch_value2  = '0;
    bus.in_dispatch_tag1    = '0;
    bus.in_dispatch_tag2    = '0;
    bus.in_cdb_valid        = 1'b0;
    bus.in_cdb_tag          = '0;
    bus.in_cdb_value        = '0;
  endtask

  task automatic disp(input logic [OW-1:0] op, input logic [TW-1:0] rob,
                      input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                      input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    bus.in_dispatch_valid   = 1'b1;
    bus.in_dispatch_op      = op;
    bus.in_dispatch_rob_tag = rob;
    bus.in_dispatch_tag1    = t1;
    bus.in_dispatch_tag2    = t2;
    bus.in_dispatch_value1  = v1;
    bus.in_dispatch_value2  = v2;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [DW-1:0] val);
    bus.in_cdb_valid = 1'b1;
    bus.in_cdb_tag   = tag;
    bus.in_cdb_value = val;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_count", 64'(bus.out_count), 0);
    check("rst_full",  64'(bus.out_full), 0);
    check("rst_valid", 64'(bus.out_alu_valid), 0);
    check("rst_op",    64'(bus.out_alu_op), 0);
    check("rst_v1",    64'(bus.out_alu_value1), 0);
    check("rst_v2",    64'(bus.out_alu_value2), 0);
    check("rst_rob",   64'(bus.out_alu_rob_tag), 0);
    rst = 1'b0;

    // Simple ADD, tags zero: issues on the edge after dispatch
    disp(OP_ADD, 4'd5, 4'd0, 4'd0, 32'd5, 32'd7);
    tick();
    check("add_disp_count", 64'(bus.out_count), 1);
    check("add_disp_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("add_valid", 64'(bus.out_alu_valid), 1);
    check("add_op",    64'(bus.out_alu_op), 64'(OP_ADD));
    check("add_v1",    64'(bus.out_alu_value1), 5);
    check("add_v2",    64'(bus.out_alu_value2), 7);
    check("add_rob",   64'(bus.out_alu_rob_tag), 5);
    check("add_count", 64'(bus.out_count), 0);
    tick();
    check("add_idle_valid", 64'(bus.out_alu_valid), 0);
    check("add_idle_hold",  64'(bus.out_alu_value1), 5);

    // A waits on tag 3, B is ready and issues first, then CDB wakes A
    disp(OP_ADD, 4'd1, 4'd3, 4'd0, 32'd0, 32'd1);
    tick();
    disp(OP_SUB, 4'd2, 4'd0, 4'd0, 32'd2, 32'd3);
    tick();
    check("ab_b_disp_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("ab_b_valid", 64'(bus.out_alu_valid), 1);
    check("ab_b_rob",   64'(bus.out_alu_rob_tag), 2);
    cdb(4'd3, 32'd9);
    tick();
    check("ab_wake_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("ab_a_valid", 64'(bus.out_alu_valid), 1);
    check("ab_a_rob",   64'(bus.out_alu_rob_tag), 1);
    check("ab_a_v1",    64'(bus.out_alu_value1), 9);
    check("ab_a_v2",    64'(bus.out_alu_value2), 1);

    // Age order beats index order: R reuses slot 0 but is younger than Q
    disp(OP_ADD, 4'd3, 4'd6, 4'd0, 32'd0, 32'd0);
    tick();
    disp(OP_ADD, 4'd4, 4'd7, 4'd0, 32'd0, 32'd0);
    tick();
    idle();
    cdb(4'd6, 32'd11);
    tick();
    idle();
    tick();
    check("age_p_valid", 64'(bus.out_alu_valid), 1);
    check("age_p_rob",   64'(bus.out_alu_rob_tag), 3);
    check("age_p_v1",    64'(bus.out_alu_value1), 11);
    disp(OP_ADD, 4'd5, 4'd7, 4'd0, 32'd0, 32'd0);
    tick();
    check("age_r_count", 64'(bus.out_count), 2);
    idle();
    cdb(4'd7, 32'd22);
    tick();
    check("age_wake_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("age_q_first", 64'(bus.out_alu_rob_tag), 4);
    check("age_q_valid", 64'(bus.out_alu_valid), 1);
    tick();
    check("age_r_second", 64'(bus.out_alu_rob_tag), 5);
    check("age_r_v1",     64'(bus.out_alu_value1), 22);
    check("age_empty",    64'(bus.out_count), 0);

    // Dispatch-time CDB bypass on tag2
    disp(OP_ADD, 4'd6, 4'd0, 4'd4, 32'd1, 32'd0);
    cdb(4'd4, 32'hDEAD);
    tick();
    check("byp_disp_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("byp_valid", 64'(bus.out_alu_valid), 1);
    check("byp_v2",    64'(bus.out_alu_value2), 64'h0000_DEAD);
    check("byp_rob",   64'(bus.out_alu_rob_tag), 6);

    // Fill all entries waiting on tag 2, then drain oldest-first
    for (int i = 0; i < D; i++) begin
      disp(OP_SUB, TW'(i), 4'd2, 4'd0, 32'(100 + i), 32'(i));
      tick();
      exp_q.push_back(TW'(i));
    end
    check("fill_count", 64'(bus.out_count), 16);
    check("fill_full",  64'(bus.out_full), 1);
    check("fill_valid", 64'(bus.out_alu_valid), 0);
    disp(OP_ADD, 4'd9, 4'd0, 4'd0, 32'd1, 32'd1);
    tick();
    check("full_ign_count", 64'(bus.out_count), 16);
    idle();
    tick();
    check("full_ign_valid", 64'(bus.out_alu_valid), 0);
    cdb(4'd2, 32'h77);
    tick();
    check("fill_wake_valid", 64'(bus.out_alu_valid), 0);
    idle();
    for (int i = 0; i < D; i++) begin
      logic [TW-1:0] exp_rob;
      tick();
      exp_rob = exp_q.pop_front();
      check("drain_valid", 64'(bus.out_alu_valid), 1);
      check("drain_rob",   64'(bus.out_alu_rob_tag), 64'(exp_rob));
      check("drain_v1",    64'(bus.out_alu_value1), 64'h77);
      check("drain_count", 64'(bus.out_count), 64'(D - 1 - i));
    end
    tick();
    check("drain_done_valid", 64'(bus.out_alu_valid), 0);

    // Flush with 5 busy (one ready) and a dispatch on the same edge
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, TW'(i + 1), 4'd9, 4'd0, 32'd0, 32'd0);
      tick();
    end
    disp(OP_ADD, 4'd5, 4'd0, 4'd0, 32'd3, 32'd3);
    tick();
    check("fl_pre_count", 64'(bus.out_count), 5);
    disp(OP_ADD, 4'd6, 4'd0, 4'd0, 32'd4, 32'd4);
    bus.in_flush = 1'b1;
    tick();
    check("fl_count", 64'(bus.out_count), 0);
    check("fl_valid", 64'(bus.out_alu_valid), 0);
    idle();
    tick();
    check("fl_post_count", 64'(bus.out_count), 0);
    check("fl_post_valid", 64'(bus.out_alu_valid), 0);

    // rdy=0 holds everything despite dispatch and CDB traffic
    disp(OP_AND, 4'd7, 4'd0, 4'd0, 32'd1, 32'd0);
    tick();
    disp(OP_AND, 4'd8, 4'd0, 4'd0, 32'd2, 32'd0);
    tick();
    check("rdy_pre_valid", 64'(bus.out_alu_valid), 1);
    check("rdy_pre_rob",   64'(bus.out_alu_rob_tag), 7);
    rdy = 1'b0;
    disp(OP_OR, 4'd9, 4'd0, 4'd0, 32'd3, 32'd0);
    cdb(4'd8, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_hold_valid", 64'(bus.out_alu_valid), 1);
      check("rdy_hold_rob",   64'(bus.out_alu_rob_tag), 7);
      check("rdy_hold_count", 64'(bus.out_count), 1);
    end
    rdy = 1'b1;
    idle();
    tick();
    check("rdy_res_valid", 64'(bus.out_alu_valid), 1);
    check("rdy_res_rob",   64'(bus.out_alu_rob_tag), 8);
    check("rdy_res_v1",    64'(bus.out_alu_value1), 2);
    check("rdy_res_count", 64'(bus.out_count), 0);
    tick();
    check("rdy_end_valid", 64'(bus.out_alu_valid), 0);

    // Reset in the middle of operation overrides a dispatch
    disp(OP_XOR, 4'd10, 4'd0, 4'd0, 32'h55, 32'h66);
    tick();
    idle();
    tick();
    check("mr_pre_valid", 64'(bus.out_alu_valid), 1);
    check("mr_pre_rob",   64'(bus.out_alu_rob_tag), 10);
    disp(OP_ADD, 4'd11, 4'd0, 4'd0, 32'd1, 32'd1);
    rst = 1'b1;
    tick();
    check("mr_valid", 64'(bus.out_alu_valid), 0);
    check("mr_rob",   64'(bus.out_alu_rob_tag), 0);
    check("mr_v1",    64'(bus.out_alu_value1), 0);
    check("mr_op",    64'(bus.out_alu_op), 0);
    check("mr_count", 64'(bus.out_count), 0);
    rst = 1'b0;
    idle();
    tick();
    check("mr_post_count", 64'(bus.out_count), 0);
    check("mr_post_valid", 64'(bus.out_alu_valid), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
